// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: opcode/opext codes, flag bit positions,
// FSM states and the instruction decoder used by both the controller and the datapath.
package cpu_pkg;

    localparam logic [3:0] OpcReg  = 4'b0000;
    localparam logic [3:0] OpcAddi = 4'b0101;
    localparam logic [3:0] OpcSubi = 4'b1001;
    localparam logic [3:0] OpcCmpi = 4'b1011;
    localparam logic [3:0] OpcAndi = 4'b0001;
    localparam logic [3:0] OpcOri  = 4'b0010;
    localparam logic [3:0] OpcXori = 4'b0011;
    localparam logic [3:0] OpcMovi = 4'b1101;
    localparam logic [3:0] OpcHalt = 4'b1111;

    localparam logic [3:0] ExtAdd = 4'b0101;
    localparam logic [3:0] ExtSub = 4'b1001;
    localparam logic [3:0] ExtCmp = 4'b1011;
    localparam logic [3:0] ExtAnd = 4'b0001;
    localparam logic [3:0] ExtOr  = 4'b0010;
    localparam logic [3:0] ExtXor = 4'b0011;
    localparam logic [3:0] ExtMov = 4'b1101;

    localparam int unsigned FlagC = 4;
    localparam int unsigned FlagL = 3;
    localparam int unsigned FlagF = 2;
    localparam int unsigned FlagN = 1;
    localparam int unsigned FlagZ = 0;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } state_e;

    typedef enum logic [3:0] {
        AluNop,
        AluAdd,
        AluSub,
        AluCmp,
        AluAnd,
        AluOr,
        AluXor,
        AluMov,
        AluHalt
    } aluOp_e;

    typedef struct packed {
        aluOp_e op;
        logic   useImm;
        logic   zeroExt;
    } decoded_t;

    function automatic decoded_t decode(input logic [15:0] instr);
        decoded_t d;
        d.op      = AluNop;
        d.useImm  = 1'b1;
        d.zeroExt = 1'b0;
        case (instr[15:12])
            OpcReg: begin
                d.useImm = 1'b0;
                case (instr[7:4])
                    ExtAdd:  d.op = AluAdd;
                    ExtSub:  d.op = AluSub;
                    ExtCmp:  d.op = AluCmp;
                    ExtAnd:  d.op = AluAnd;
                    ExtOr:   d.op = AluOr;
                    ExtXor:  d.op = AluXor;
                    ExtMov:  d.op = AluMov;
                    default: d.op = AluNop;
                endcase
            end
            OpcAddi: d.op = AluAdd;
            OpcSubi: d.op = AluSub;
            OpcCmpi: d.op = AluCmp;
            OpcAndi: d.op = AluAnd;
            OpcOri:  d.op = AluOr;
            OpcXori: d.op = AluXor;
            OpcMovi: begin
                d.op      = AluMov;
                d.zeroExt = 1'b1;
            end
            OpcHalt: d.op = AluHalt;
            default: d.op = AluNop;
        endcase
        return d;
    endfunction

    function automatic logic writesReg(input aluOp_e op);
        return op inside {AluAdd, AluSub, AluAnd, AluOr, AluXor, AluMov};
    endfunction

    function automatic logic setsFlags(input aluOp_e op);
        return op inside {AluAdd, AluSub, AluCmp};
    endfunction

endpackage

// File: rtl/cpu_multicycle_if.sv
// Instruction-fetch bus between the CPU (master) and instruction memory (slave).
interface cpu_multicycle_if #(
    parameter int REG_WIDTH = 16
) ();
    logic                 mem_req;
    logic [REG_WIDTH-1:0] mem_addr;
    logic                 mem_ack;
    logic [15:0]          mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/cpu_controller.sv
// Multicycle sequencer FETCH -> DECODE -> EXECUTE -> WRITEBACK with a terminal HALT;
// produces every datapath enable and the operand-B select.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        memAck,
    input  logic [15:0] ir,
    output logic        memReq,
    output logic        irEn,
    output logic        operandEn,
    output logic        resultEn,
    output logic        flagsEn,
    output logic        regWe,
    output logic        pcEn,
    output logic        opBSel,
    output logic        retire,
    output logic        halted
);
    state_e   stateQ, stateD;
    decoded_t dec;

    assign dec = decode(ir);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stateQ <= StFetch;
        else       stateQ <= stateD;
    end

    always_comb begin
        stateD    = stateQ;
        memReq    = 1'b0;
        irEn      = 1'b0;
        operandEn = 1'b0;
        resultEn  = 1'b0;
        flagsEn   = 1'b0;
        regWe     = 1'b0;
        pcEn      = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        opBSel    = dec.useImm;
        unique case (stateQ)
            StFetch: begin
                memReq = 1'b1;
                if (memAck) begin
                    irEn   = 1'b1;
                    stateD = StDecode;
                end
            end
            StDecode: begin
                operandEn = 1'b1;
                stateD    = StExecute;
            end
            StExecute: begin
                resultEn = 1'b1;
                flagsEn  = setsFlags(dec.op);
                stateD   = (dec.op == AluHalt) ? StHalt : StWriteback;
            end
            StWriteback: begin
                regWe  = writesReg(dec.op);
                pcEn   = 1'b1;
                retire = 1'b1;
                stateD = StFetch;
            end
            StHalt: halted = 1'b1;
            default: stateD = StFetch;
        endcase
    end
endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle CPU top: controller FSM driving a datapath of enable flops, a register
// file (not reset) and a single ALU shared by register and immediate forms.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    cpu_multicycle_if.master         mem,
    input  logic [REG_ADDR_BITS-1:0] dbg_addr,
    output logic [REG_WIDTH-1:0]     dbg_data,
    output logic [4:0]               flags,
    output logic [REG_WIDTH-1:0]     result,
    output logic                     retire,
    output logic                     halted
);
    localparam int RegDepth = 2 ** REG_ADDR_BITS;
    localparam int Msb      = REG_WIDTH - 1;

    logic [15:0]              ir;
    logic [REG_WIDTH-1:0]     pc, opA, opB, immExt, aluOut;
    logic [REG_WIDTH:0]       sum, diff;
    logic [4:0]               aluFlags;
    logic [REG_WIDTH-1:0]     regFile [RegDepth];
    logic [REG_ADDR_BITS-1:0] rdAddr, rsAddr;
    logic memReq, irEn, operandEn, resultEn, flagsEn, regWe, pcEn, opBSel;
    decoded_t dec;

    cpu_controller u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .memAck    (mem.mem_ack),
        .ir        (ir),
        .memReq    (memReq),
        .irEn      (irEn),
        .operandEn (operandEn),
        .resultEn  (resultEn),
        .flagsEn   (flagsEn),
        .regWe     (regWe),
        .pcEn      (pcEn),
        .opBSel    (opBSel),
        .retire    (retire),
        .halted    (halted)
    );

    assign dec          = decode(ir);
    assign rdAddr       = ir[8 +: REG_ADDR_BITS];
    assign rsAddr       = ir[0 +: REG_ADDR_BITS];
    assign mem.mem_req  = memReq;
    assign mem.mem_addr = pc;
    assign dbg_data     = regFile[dbg_addr];

    always_comb begin
        immExt = dec.zeroExt ? REG_WIDTH'(ir[7:0]) : REG_WIDTH'($signed(ir[7:0]));
    end

    // Extra top bit of sum/diff is the carry out / borrow.
    always_comb begin
        sum      = {1'b0, opA} + {1'b0, opB};
        diff     = {1'b0, opA} - {1'b0, opB};
        aluOut   = '0;
        aluFlags = flags;
        case (dec.op)
            AluAdd:         aluOut = sum[Msb:0];
            AluSub, AluCmp: aluOut = diff[Msb:0];
            AluAnd:         aluOut = opA & opB;
            AluOr:          aluOut = opA | opB;
            AluXor:         aluOut = opA ^ opB;
            AluMov:         aluOut = opB;
            default:        aluOut = '0;
        endcase
        if (setsFlags(dec.op)) begin
            if (dec.op == AluAdd) begin
                aluFlags[FlagC] = sum[REG_WIDTH];
                aluFlags[FlagF] = (opA[Msb] == opB[Msb]) && (aluOut[Msb] != opA[Msb]);
            end else begin
                aluFlags[FlagC] = diff[REG_WIDTH];
                aluFlags[FlagF] = (opA[Msb] != opB[Msb]) && (aluOut[Msb] != opA[Msb]);
            end
            aluFlags[FlagL] = opA < opB;
            aluFlags[FlagN] = $signed(opA) < $signed(opB);
            aluFlags[FlagZ] = (aluOut == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir     <= '0;
            pc     <= '0;
            opA    <= '0;
            opB    <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            if (irEn) ir <= mem.mem_rdata;
            if (operandEn) begin
                opA <= regFile[rdAddr];
                opB <= opBSel ? immExt : regFile[rsAddr];
            end
            if (resultEn) result <= aluOut;
            if (flagsEn)  flags  <= aluFlags;
            if (pcEn)     pc     <= pc + REG_WIDTH'(1);
        end
    end

    // Register contents survive reset.
    always_ff @(posedge clk) begin
        if (regWe) regFile[rdAddr] <= result;
    end
endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: directed programs and a random instruction stream, each
// instruction checked against an instruction-level reference model.
module tb_cpu_multicycle;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dbgAddr;
    logic [15:0] dbgData, result;
    logic [4:0]  flags;
    logic        retire, halted;

    logic        rst8;
    logic [2:0]  dbgAddr8;
    logic [7:0]  dbgData8, result8;
    logic [4:0]  flags8;
    logic        retire8, halted8;

    logic [15:0] imem [1024];
    logic [15:0] prog [$];
    int          retireTimes [$];

    logic [15:0] mRegs [16];
    bit          mKnown [16];
    logic [4:0]  mFlags;
    logic [15:0] mResult, mPc;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    cpu_multicycle_if #(.REG_WIDTH(16)) bus ();
    assign bus.mem_rdata = imem[bus.mem_addr[9:0]];

    cpu_multicycle #(.REG_WIDTH(16), .REG_ADDR_BITS(4)) dut (
        .clk      (clk),
        .reset    (rst),
        .mem      (bus),
        .dbg_addr (dbgAddr),
        .dbg_data (dbgData),
        .flags    (flags),
        .result   (result),
        .retire   (retire),
        .halted   (halted)
    );

    // Narrow instance: NOPs everywhere except MOVI r1,0x5A at 0xFE, to reach PC wrap quickly.
    cpu_multicycle_if #(.REG_WIDTH(8)) bus8 ();
    assign bus8.mem_ack   = 1'b1;
    assign bus8.mem_rdata = (bus8.mem_addr == 8'hFE) ? 16'hD15A : 16'h0000;

    cpu_multicycle #(.REG_WIDTH(8), .REG_ADDR_BITS(3)) dut8 (
        .clk      (clk),
        .reset    (rst8),
        .mem      (bus8),
        .dbg_addr (dbgAddr8),
        .dbg_data (dbgData8),
        .flags    (flags8),
        .result   (result8),
        .retire   (retire8),
        .halted   (halted8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ack);
        bus.mem_ack = ack;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic int toSigned(input int unsigned v);
        return (v >= 32768) ? int'(v) - 65536 : int'(v);
    endfunction

    // Architectural effect of one instruction, from the instruction-set rules.
    task automatic modelExec(input logic [15:0] instr, output bit isHalt, output bit resValid);
        logic [3:0]  opc, code, rd;
        int unsigned a, b, res;
        int          sa, sb, sr, kind;
        bit          c, l, f, n;
        opc = instr[15:12];
        rd  = instr[11:8];
        a   = mRegs[rd];
        if (opc == 4'h0) begin
            b    = mRegs[instr[3:0]];
            code = instr[7:4];
        end else begin
            b    = instr[7] ? (32'hFF00 | instr[7:0]) : instr[7:0];
            code = opc;
        end
        // kind: 0 nop, 1 add, 2 sub, 3 cmp, 4 and, 5 or, 6 xor, 7 mov, 8 halt
        if (opc == 4'hF) kind = 8;
        else if (opc == 4'hD) begin
            kind = 7;
            b    = instr[7:0];
        end else begin
            case (code)
                4'h5:    kind = 1;
                4'h9:    kind = 2;
                4'hB:    kind = 3;
                4'h1:    kind = 4;
                4'h2:    kind = 5;
                4'h3:    kind = 6;
                4'hD:    kind = 7;
                default: kind = 0;
            endcase
        end
        sa = toSigned(a);
        sb = toSigned(b);
        res = 0;
        c = 0; f = 0;
        case (kind)
            1: begin
                res = (a + b) % 65536;
                c   = (a + b) > 65535;
                sr  = sa + sb;
                f   = (sr > 32767) || (sr < -32768);
            end
            2, 3: begin
                res = (a + 65536 - b) % 65536;
                c   = a < b;
                sr  = sa - sb;
                f   = (sr > 32767) || (sr < -32768);
            end
            4: res = a & b;
            5: res = a | b;
            6: res = a ^ b;
            7: res = b;
            default: res = 0;
        endcase
        l = a < b;
        n = sa < sb;
        if (kind >= 1 && kind <= 3) mFlags = {c, l, f, n, res == 0};
        if (kind inside {1, 2, 4, 5, 6, 7}) begin
            mRegs[rd]  = 16'(res);
            mKnown[rd] = 1'b1;
        end
        resValid = (kind >= 1 && kind <= 7);
        if (resValid) mResult = 16'(res);
        isHalt = (kind == 8);
    endtask

    // Runs one instruction from FETCH entry; waits = cycles mem_ack is held low first.
    task automatic execOne(input int waits, output bit isHalt);
        logic [15:0] instr;
        logic [3:0]  rd;
        bit          resValid;
        instr = imem[mPc[9:0]];
        rd    = instr[11:8];
        for (int i = 0; i < waits; i++) begin
            check("fetch_wait_req", bus.mem_req, 1);
            check("fetch_wait_addr", bus.mem_addr, mPc);
            step(1'b0);
        end
        check("fetch_req", bus.mem_req, 1);
        check("fetch_addr", bus.mem_addr, mPc);
        check("fetch_retire", retire, 0);
        step(1'b1);
        check("decode_req", bus.mem_req, 0);
        check("decode_retire", retire, 0);
        step(1'($urandom));
        check("execute_req", bus.mem_req, 0);
        check("execute_retire", retire, 0);
        step(1'($urandom));
        modelExec(instr, isHalt, resValid);
        if (isHalt) begin
            check("halt_halted", halted, 1);
            check("halt_retire", retire, 0);
            check("halt_req", bus.mem_req, 0);
            check("halt_flags", flags, mFlags);
            return;
        end
        check($sformatf("wb_retire %h", instr), retire, 1);
        check("wb_halted", halted, 0);
        check($sformatf("flags %h", instr), flags, mFlags);
        if (resValid) check($sformatf("result %h", instr), result, mResult);
        retireTimes.push_back(cycle);
        step(1'($urandom));
        mPc = mPc + 16'd1;
        if (mKnown[rd]) begin
            dbgAddr = rd;
            #1;
            check($sformatf("reg r%0d after %h", rd, instr), dbgData, mRegs[rd]);
        end
    endtask

    task automatic runToHalt(input int maxWait);
        bit h;
        h = 0;
        for (int n = 0; n < 1000 && !h; n++) execOne($urandom_range(0, maxWait), h);
        check("program_halted", h, 1);
    endtask

    task automatic loadAndReset();
        rst = 1'b1;
        #1;
        check("rst_flags", flags, 0);
        check("rst_result", result, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);
        for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
        foreach (prog[i]) imem[i] = prog[i];
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        #1;
        mPc = 16'h0000; mFlags = 5'b0; mResult = 16'h0000;
        check("post_rst_req", bus.mem_req, 1);
        check("post_rst_addr", bus.mem_addr, 0);
        retireTimes.delete();
    endtask

    initial begin
        bit h;
        logic [3:0] opc, ext;
        rst = 1'b1; rst8 = 1'b1; bus.mem_ack = 1'b0; dbgAddr = '0; dbgAddr8 = 3'd1;
        for (int i = 0; i < 16; i++) begin mRegs[i] = '0; mKnown[i] = 1'b0; end
        step(1'b0);

        // MOVI r1,5; MOVI r2,0xFF; ADD r2,r1; HALT with ack always high.
        prog = '{16'hD105, 16'hD2FF, 16'h0251, 16'hF000};
        loadAndReset();
        runToHalt(0);
        check("ret_count", retireTimes.size(), 3);
        if (retireTimes.size() == 3) begin
            check("ret_gap1", retireTimes[1] - retireTimes[0], 4);
            check("ret_gap2", retireTimes[2] - retireTimes[1], 4);
        end
        dbgAddr = 4'd2; #1;
        check("r2_sum", dbgData, 16'h0104);
        repeat (5) step(1'b1);
        check("halt_stays", halted, 1);
        check("halt_no_req", bus.mem_req, 0);
        check("halt_no_retire", retire, 0);

        // ADDI overflow into the sign bit.
        prog = '{16'hD17F, 16'h0151, 16'h0151, 16'h0151, 16'h0151, 16'h0151, 16'h0151,
                 16'h0151, 16'h0151, 16'hD4FF, 16'h0124, 16'h5101, 16'hF000};
        loadAndReset();
        dbgAddr = 4'd2; #1;
        check("reg_survives_reset", dbgData, 16'h0104);
        runToHalt(2);
        dbgAddr = 4'd1; #1;
        check("addi_r1", dbgData, 16'h8000);
        check("addi_flags", flags, 5'b00100);

        // CMPI equal: Z only, no write, result zero.
        prog = '{16'hD303, 16'hB303, 16'hF000};
        loadAndReset();
        execOne(0, h);
        execOne(1, h);
        check("cmpi_flags", flags, 5'b00001);
        check("cmpi_result", result, 16'h0000);
        dbgAddr = 4'd3; #1;
        check("cmpi_r3", dbgData, 16'h0003);
        execOne(0, h);

        // Fetch stalled five cycles.
        prog = '{16'hD533, 16'hF000};
        loadAndReset();
        execOne(5, h);
        check("stall_retire_cycle", retireTimes.size() == 1 ? retireTimes[0] - (cycle - 1) : -1, 0);
        check("stall_pc", bus.mem_addr, 16'h0001);
        execOne(0, h);

        // Reset during EXECUTE of ADD r1,r1.
        prog = '{16'hD121, 16'hB121, 16'h0151, 16'hF000};
        loadAndReset();
        execOne(0, h);
        execOne(0, h);
        step(1'b1);
        step(1'b0);
        check("pre_rst_flags", flags, 5'b00001);
        #3;
        rst = 1'b1;
        #1;
        check("midexec_flags", flags, 0);
        check("midexec_pc", bus.mem_addr, 0);
        check("midexec_result", result, 0);
        check("midexec_retire", retire, 0);
        step(1'b0);
        rst = 1'b0;
        #1;
        mPc = 16'h0000; mFlags = 5'b0; mResult = 16'h0000;
        check("midexec_req", bus.mem_req, 1);
        dbgAddr = 4'd1; #1;
        check("midexec_r1", dbgData, 16'h0021);

        // Random stream: initialise all registers, then random ops, then HALT.
        prog.delete();
        for (int r = 0; r < 16; r++) prog.push_back({4'hD, 4'(r), 8'($urandom)});
        for (int k = 0; k < 120; k++) begin
            int sel;
            sel = $urandom_range(0, 15);
            case ($urandom_range(0, 6))
                0: ext = 4'h5; 1: ext = 4'h9; 2: ext = 4'hB; 3: ext = 4'h1;
                4: ext = 4'h2; 5: ext = 4'h3; default: ext = 4'hD;
            endcase
            if (sel < 5) begin
                opc = 4'h0;
                if ($urandom_range(0, 7) == 0) ext = 4'($urandom);
            end else if (sel < 14) begin
                opc = ext;
                ext = 4'($urandom);
            end else begin
                case ($urandom_range(0, 6))
                    0: opc = 4'h4; 1: opc = 4'h6; 2: opc = 4'h7; 3: opc = 4'h8;
                    4: opc = 4'hA; 5: opc = 4'hC; default: opc = 4'hE;
                endcase
                ext = 4'($urandom);
            end
            prog.push_back({opc, 4'($urandom), ext, 4'($urandom)});
        end
        prog.push_back(16'hF000);
        loadAndReset();
        runToHalt(3);

        // PC wrap on the narrow instance.
        step(1'b0);
        rst8 = 1'b0;
        #1;
        check("w8_addr0", bus8.mem_addr, 0);
        repeat (255 * 4) step(1'b0);
        check("w8_addr_top", bus8.mem_addr, 8'hFF);
        check("w8_req", bus8.mem_req, 1);
        check("w8_result", result8, 8'h5A);
        check("w8_r1", dbgData8, 8'h5A);
        check("w8_flags", flags8, 0);
        check("w8_retire", retire8, 0);
        check("w8_halted", halted8, 0);
        repeat (4) step(1'b0);
        check("w8_wrap", bus8.mem_addr, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 16, meaning datapath, register, PC and instruction-memory address width.
REQ-002 SHALL have parameter REG_ADDR_BITS, default 4, meaning register-address width; register file depth is 2**REG_ADDR_BITS.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  instruction fetch request.
REQ-006 SHALL have port mem_addr  output  REG_WIDTH  fetch address, equal to PC.
REQ-007 SHALL have port mem_ack  input  1  fetch data valid.
REQ-008 SHALL have port mem_rdata  input  16  instruction word.
REQ-009 SHALL have port dbg_addr  input  REG_ADDR_BITS  debug register select.
REQ-010 SHALL have port dbg_data  output  REG_WIDTH  combinational read of register dbg_addr.
REQ-011 SHALL have port flags  output  5  {C,L,F,N,Z} flag register.
REQ-012 SHALL have port result  output  REG_WIDTH  registered ALU result of the last EXECUTE.
REQ-013 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-014 SHALL have port halted  output  1  high while in HALT.

Function
REQ-015 Instruction format SHALL be [15:12] opcode, [11:8] Rdest, [7:4] opext, [3:0] Rsrc; immediate forms SHALL use [7:0] as the immediate. Register fields SHALL use their low REG_ADDR_BITS bits.
REQ-016 Opcode 0000 SHALL be register form, with opext selecting the operation: 0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV. Any other opext SHALL be a NOP.
REQ-017 Opcodes 0101/1001/1011/0001/0010/0011 SHALL be ADDI/SUBI/CMPI/ANDI/ORI/XORI with a sign-extended immediate. Opcode 1101 SHALL be MOVI with a zero-extended immediate. Opcode 1111 SHALL be HALT. All other opcodes SHALL be a NOP.
REQ-018 Operand A SHALL be Rdest; operand B SHALL be Rsrc or the extended immediate. SUB/CMP SHALL compute A-B. All arithmetic SHALL be modulo 2**REG_WIDTH.
REQ-019 The FSM SHALL have states FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH: mem_req=1. On a cycle with mem_ack=1, latch mem_rdata into IR and go to DECODE; otherwise stay in FETCH.
- DECODE: read operands, go to EXECUTE.
- EXECUTE: latch result, update flags, go to WRITEBACK; HALT goes to HALT instead.
- WRITEBACK: write Rdest, PC<=PC+1, retire=1, go to FETCH.
- HALT: stay until reset; retire is not pulsed.
REQ-020 Minimum latency SHALL be 4 cycles per instruction; each extra cycle without mem_ack SHALL add one cycle.
REQ-021 mem_req SHALL be low outside FETCH, and mem_ack SHALL be ignored outside FETCH.
REQ-022 CMP, CMPI and NOP SHALL NOT write the register file. All other ALU operations SHALL write Rdest in WRITEBACK.
REQ-023 ADD/SUB/CMP and their immediate forms SHALL update all five flags:
- C: unsigned carry out (ADD) or borrow (SUB/CMP).
- L: A<B unsigned.
- F: signed overflow.
- N: A<B signed.
- Z: result==0.
Logic operations, MOV, MOVI and NOP SHALL leave the flags unchanged.
REQ-024 PC SHALL wrap from 2**REG_WIDTH-1 to 0.
REQ-025 When Rdest==Rsrc, both operands SHALL read the pre-write value.

Reset
REQ-026 Asserting reset at any time, including mid-FETCH, SHALL immediately and asynchronously force: state=FETCH, PC=0, IR=0, flags=0, result=0, retire=0, halted=0. mem_req SHALL read 1 once reset deasserts.
REQ-027 Register-file contents SHALL NOT be cleared by reset.

Structure
REQ-028 Opcode/opext constants, flag bit positions and state encodings SHALL live in shared package cpu_pkg.
REQ-029 The FSM SHALL be a sub-module cpu_controller. It SHALL drive the enables for PC, IR, result, flags and register write, and the operand-B select. The datapath SHALL reuse the existing register file, ALU and enable-flop blocks.

Verification
REQ-030 Memory {MOVI r1,0x05; MOVI r2,0xFF; ADD r2,r1; HALT} with mem_ack tied high -> dbg r2=0x0104; retire pulses 3 times, 4 cycles apart; halted=1.
REQ-031 r1=0x7FFF, ADDI r1,1 -> r1=0x8000; F=1, N=0, C=0, Z=0.
REQ-032 r3=0x0003, CMPI r3,3 -> Z=1, C=0, L=0; r3 unchanged; result=0x0000.
REQ-033 mem_ack withheld 5 cycles in FETCH -> mem_req stays 1, IR unchanged, PC unchanged; instruction retires 9 cycles after FETCH entry.
REQ-034 PC preset to 0xFFFF via fetch of NOPs from 0xFFFF -> next mem_addr=0x0000.
REQ-035 Reset asserted mid-EXECUTE of ADD r1,r1 -> r1 not written, flags=0, PC=0, mem_req=1 after reset release.
